// File: rtl/mips_defs.sv
// mips_defs: shared widths, reset PC, fetch FSM encodings and branch-target helper.
package mips_defs;

    localparam int          DEF_XLEN        = 32;
    localparam logic [31:0] DEF_RESET_PC    = 32'h0;
    localparam int          DEF_QUEUE_DEPTH = 4;
    localparam int          DEF_PC_STEP     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    // Computed at 64 bits; callers truncate to XLEN, which gives the modulo-2^XLEN result.
    function automatic logic [63:0] branch_target(input logic [63:0] pc, input logic [15:0] imm16, input logic [63:0] step);
        logic [63:0] t;
        t = pc + step + {{46{imm16[15]}}, imm16, 2'b00};
        return {t[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular prefetch FIFO with flush, occupancy count and push/pop.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;

    assign full = count == CW'(DEPTH);
    assign head = count == '0 ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clock) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
        if (!reset)
            assert (!(push && full && !pop));
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: registered-PC instruction fetch with wait-state handshake,
// branch redirect/kill and a prefetch queue feeding decode.
module mips_fetch_unit
    import mips_defs::*;
#(
    parameter int              XLEN        = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEF_RESET_PC),
    parameter int              QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int              PC_STEP     = DEF_PC_STEP
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic                          imem_req,
    output logic [XLEN-1:0]               imem_addr,
    input  logic                          imem_ack,
    input  logic [XLEN-1:0]               imem_rdata,
    input  logic                          branch_valid,
    input  logic [XLEN-1:0]               branch_pc,
    input  logic [15:0]                   branch_imm16,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [XLEN-1:0]               instr_data,
    output logic [XLEN-1:0]               instr_pc,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t     state;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  step;
    logic             push;
    logic             pop;
    logic [CW-1:0]    occ_next;

    assign target      = XLEN'(branch_target(64'(branch_pc), branch_imm16, 64'(PC_STEP)));
    assign step        = XLEN'(PC_STEP);
    assign instr_valid = queue_count != '0;
    assign pop         = instr_valid & instr_ready;
    assign push        = (state == REQ) & imem_ack & ~branch_valid;
    assign occ_next    = queue_count + CW'(push) - CW'(pop);

    fetch_queue #(
        .WIDTH (2 * XLEN),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (branch_valid),
        .push      (push),
        .pop       (pop),
        .push_data ({imem_addr, imem_rdata}),
        .head      ({instr_pc, instr_data}),
        .count     (queue_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
            imem_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_valid) begin
                        fetch_pc <= target;
                    end else if (queue_count < CW'(QUEUE_DEPTH)) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (branch_valid) begin
                        fetch_pc <= target;
                        // An outstanding request must complete at its own address before redirecting.
                        if (imem_ack)
                            imem_addr <= target;
                        else
                            state <= KILL;
                    end else if (imem_ack) begin
                        fetch_pc <= imem_addr + step;
                        if (occ_next < CW'(QUEUE_DEPTH)) begin
                            imem_addr <= imem_addr + step;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                KILL: begin
                    if (branch_valid)
                        fetch_pc <= target;
                    if (imem_ack) begin
                        state     <= REQ;
                        imem_addr <= branch_valid ? target : fetch_pc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
